viterbi_link_ctrl: RTL
======================

VITERBI_LINK_CTRL -- requirements
Module: viterbi_link_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 256: data bits per frame (1..65535).
REQ-002 Parameter TAIL_LEN, default 8: zero flush bits after data, for trellis termination.
REQ-003 Parameter DEC_LATENCY, default 40: cycles from enc_bit_o issue to the matching dec_bit_i; includes the channel register.
REQ-004 Parameter SEED, default 16'hACE1: PRBS seed; nonzero.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start_i  in  1  frame start pulse; sampled only in IDLE.
REQ-008 err_en_i  in  1  enables channel error injection.
REQ-009 err_period_i  in  8  injection period, in valid symbols.
REQ-010 err_burst_i  in  8  corrupted symbols per period.
REQ-011 enc_bit_o  out  1  data bit to encoder.
REQ-012 enc_en_o  out  1  encoder enable.
REQ-013 enc_valid_i  in  1  encoder output valid.
REQ-014 enc_sym_i  in  2  encoder output symbol.
REQ-015 dec_en_o  out  1  decoder enable.
REQ-016 dec_sym_o  out  2  symbol to decoder, possibly corrupted.
REQ-017 dec_bit_i  in  1  decoded bit.
REQ-018 busy_o  out  1  high in every state except IDLE.
REQ-019 done_o  out  1  one-cycle frame-complete pulse.
REQ-020 bit_err_cnt_o  out  16  decoded-bit mismatches in the last or current frame.
REQ-021 inj_err_cnt_o  out  16  symbols corrupted in the last or current frame.

Function
REQ-022 FSM states: IDLE, DATA, TAIL, DRAIN, DONE.
- IDLE->DATA on start_i.
- DATA->TAIL after FRAME_LEN cycles.
- TAIL->DRAIN after TAIL_LEN cycles; TAIL_LEN=0 goes DATA->DRAIN directly.
- DRAIN->DONE after DEC_LATENCY cycles.
- DONE->IDLE after one cycle.
REQ-023 start_i while busy_o=1 is ignored with no effect.
REQ-024 On the IDLE->DATA transition:
- PRBS reloads SEED.
- Both counters and the injection phase counter clear.
REQ-025 PRBS: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1; enc_bit_o = lfsr[0] in DATA; advances once per DATA cycle.
REQ-026 enc_en_o = 1 in DATA and TAIL only; enc_bit_o = 0 outside DATA.
REQ-027 Channel is one registered stage: dec_en_o <= enc_valid_i; dec_sym_o <= enc_sym_i, with bit 0 inverted when injecting.
REQ-028 Phase counter:
- Advances on each enc_valid_i cycle.
- Wraps from err_period_i-1 to 0.
- Injection occurs when err_en_i=1, err_period_i!=0, enc_valid_i=1 and phase >= err_period_i - err_burst_i.
REQ-029 err_burst_i >= err_period_i corrupts every valid symbol. err_period_i=0 or err_burst_i=0 disables injection.
REQ-030 inj_err_cnt_o increments once per injected symbol and saturates at 16'hFFFF.
REQ-031 Reference delay line is DEC_LATENCY deep. Each stage holds a bit and a tag; the tag is 1 only for DATA-state bits.
REQ-032 bit_err_cnt_o increments when the delayed tag is 1 and dec_bit_i differs from the delayed bit; saturates at 16'hFFFF. Tail bits are never compared.
REQ-033 Counters hold their values from DONE until the next accepted start_i.
REQ-034 done_o = 1 only in DONE.

Reset
REQ-035 On rst=0, asynchronously:
- State = IDLE.
- All outputs = 0.
- PRBS = SEED.
- Delay-line tags = 0.
- Phase counter and both counters = 0.
REQ-036 Reset during any state aborts the frame; done_o is not asserted.

Structure
REQ-037 Package viterbi_pkg holds the state enum, LFSR tap constant, and parameter defaults.
REQ-038 Sub-module prbs_gen (16-bit LFSR with load and advance) is instantiated once.

Verification
REQ-039 err_en_i=0, FRAME_LEN=256, ideal loopback decoder model with latency DEC_LATENCY -> bit_err_cnt_o=0, inj_err_cnt_o=0, done_o at cycle 256+8+40+1 after start.
REQ-040 err_en_i=1, period=17, burst=4, 264 valid symbols -> inj_err_cnt_o=60 (15 full periods x4, remaining 9 symbols inject 0); injected symbols differ only in bit 0.
REQ-041 period=4, burst=9 -> every valid symbol inverted; inj_err_cnt_o=264.
REQ-042 Decoder model flips every 10th data bit -> bit_err_cnt_o=25; tail-bit flips add 0.
REQ-043 start_i pulsed again mid-DATA -> ignored; rst=0 mid-DRAIN -> all outputs 0 immediately, no done_o, next start_i restarts from SEED.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi loopback link controller.
package viterbi_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_TAIL,
      S_DRAIN,
      S_DONE
   } state_t;

   // Feedback taps for a right-shifting LFSR, x^16+x^14+x^13+x^11+1 -> bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam int          FRAME_LEN_DEF   = 256;
   localparam int          TAIL_LEN_DEF    = 8;
   localparam int          DEC_LATENCY_DEF = 40;
   localparam logic [15:0] SEED_DEF        = 16'hACE1;

endpackage

// File: rtl/prbs_gen.sv
// 16-bit Fibonacci LFSR test-pattern source with synchronous reload and step enable.
module prbs_gen
   import viterbi_pkg::*;
#(
   parameter logic [15:0] SEED = SEED_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic advance,
   output logic out_bit
);

   logic [15:0] lfsr_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_reg <= SEED;
      end else if (load) begin
         lfsr_reg <= SEED;
      end else if (advance) begin
         lfsr_reg <= {^(lfsr_reg & LFSR_TAPS), lfsr_reg[15:1]};
      end
   end

   assign out_bit = lfsr_reg[0];

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Frame controller for an encoder/Viterbi-decoder loopback: PRBS source, registered
// channel with periodic burst error injection, and a delayed-reference bit checker.
module viterbi_link_ctrl
   import viterbi_pkg::*;
#(
   parameter int          FRAME_LEN   = FRAME_LEN_DEF,
   parameter int          TAIL_LEN    = TAIL_LEN_DEF,
   parameter int          DEC_LATENCY = DEC_LATENCY_DEF,
   parameter logic [15:0] SEED        = SEED_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        err_en_i,
   input  logic [7:0]  err_period_i,
   input  logic [7:0]  err_burst_i,
   output logic        enc_bit_o,
   output logic        enc_en_o,
   input  logic        enc_valid_i,
   input  logic [1:0]  enc_sym_i,
   output logic        dec_en_o,
   output logic [1:0]  dec_sym_o,
   input  logic        dec_bit_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] bit_err_cnt_o,
   output logic [15:0] inj_err_cnt_o
);

   localparam logic [15:0] DATA_LAST  = 16'(FRAME_LEN - 1);
   localparam logic [15:0] TAIL_LAST  = 16'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
   localparam logic [15:0] DRAIN_LAST = 16'(DEC_LATENCY - 1);

   state_t      state_reg;
   logic [15:0] step_reg;
   logic        in_data_reg;
   logic        start_acc;
   logic        in_frame;
   logic        prbs_bit;
   logic        inject;
   logic [8:0]  reach;
   logic [7:0]  phase_reg;
   logic [DEC_LATENCY-1:0] ref_bit_reg;
   logic [DEC_LATENCY-1:0] ref_tag_reg;

   assign start_acc = (state_reg == S_IDLE) && start_i;
   assign in_frame  = (state_reg == S_DATA) || (state_reg == S_TAIL) || (state_reg == S_DRAIN);

   prbs_gen #(
      .SEED(SEED)
   ) u_prbs (
      .clk     (clk),
      .rst     (rst),
      .load    (start_acc),
      .advance (state_reg == S_DATA),
      .out_bit (prbs_bit)
   );

   assign enc_bit_o = in_data_reg & prbs_bit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         step_reg    <= '0;
         in_data_reg <= 1'b0;
         enc_en_o    <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start_i) begin
                  state_reg   <= S_DATA;
                  step_reg    <= '0;
                  in_data_reg <= 1'b1;
                  enc_en_o    <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            S_DATA: begin
               if (step_reg == DATA_LAST) begin
                  step_reg    <= '0;
                  in_data_reg <= 1'b0;
                  if (TAIL_LEN == 0) begin
                     state_reg <= S_DRAIN;
                     enc_en_o  <= 1'b0;
                  end else begin
                     state_reg <= S_TAIL;
                  end
               end else begin
                  step_reg <= step_reg + 16'd1;
               end
            end
            S_TAIL: begin
               if (step_reg == TAIL_LAST) begin
                  step_reg  <= '0;
                  state_reg <= S_DRAIN;
                  enc_en_o  <= 1'b0;
               end else begin
                  step_reg <= step_reg + 16'd1;
               end
            end
            S_DRAIN: begin
               if (step_reg == DRAIN_LAST) begin
                  step_reg  <= '0;
                  state_reg <= S_DONE;
                  done_o    <= 1'b1;
               end else begin
                  step_reg <= step_reg + 16'd1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               busy_o    <= 1'b0;
            end
            default: begin
               state_reg   <= S_IDLE;
               in_data_reg <= 1'b0;
               enc_en_o    <= 1'b0;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

   // phase >= period - burst, evaluated without underflow; burst >= period hits every symbol
   assign reach  = 9'(phase_reg) + 9'(err_burst_i);
   assign inject = err_en_i && (err_period_i != 8'd0) && (err_burst_i != 8'd0) &&
                   enc_valid_i && (reach >= 9'(err_period_i));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_en_o      <= 1'b0;
         dec_sym_o     <= 2'b00;
         phase_reg     <= 8'd0;
         inj_err_cnt_o <= 16'd0;
      end else begin
         dec_en_o  <= enc_valid_i;
         dec_sym_o <= enc_sym_i ^ {1'b0, inject};
         if (start_acc) begin
            phase_reg <= 8'd0;
         end else if (enc_valid_i) begin
            phase_reg <= (phase_reg >= err_period_i - 8'd1) ? 8'd0 : phase_reg + 8'd1;
         end
         if (start_acc) begin
            inj_err_cnt_o <= 16'd0;
         end else if (inject && in_frame && (inj_err_cnt_o != 16'hFFFF)) begin
            inj_err_cnt_o <= inj_err_cnt_o + 16'd1;
         end
      end
   end

   // Reference line: the oldest stage lines up with dec_bit_i; only DATA bits carry a tag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_bit_reg   <= '0;
         ref_tag_reg   <= '0;
         bit_err_cnt_o <= 16'd0;
      end else begin
         ref_bit_reg <= DEC_LATENCY'({ref_bit_reg, enc_bit_o});
         ref_tag_reg <= DEC_LATENCY'({ref_tag_reg, in_data_reg});
         if (start_acc) begin
            bit_err_cnt_o <= 16'd0;
         end else if (ref_tag_reg[DEC_LATENCY-1] && (dec_bit_i != ref_bit_reg[DEC_LATENCY-1]) &&
                      (bit_err_cnt_o != 16'hFFFF)) begin
            bit_err_cnt_o <= bit_err_cnt_o + 16'd1;
         end
      end
   end

endmodule
